// File: rtl/gpio_irq_in_if.sv
// CPU-side register bus and pad inputs of gpio_irq_in, grouped for port connection.
// master drives pads, write data and strobes; slave is the gpio_irq_in block.
interface gpio_irq_in_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_pins;
    logic [WIDTH-1:0] i_Data;
    logic             i_we_ien;
    logic             i_we_edge;
    logic             i_we_pol;
    logic             i_we_clr;
    logic [WIDTH-1:0] o_level;
    logic [WIDTH-1:0] o_status;
    logic [WIDTH-1:0] o_ien;
    logic [WIDTH-1:0] o_edge;
    logic [WIDTH-1:0] o_pol;
    logic             o_irq;

    modport master (
        output i_pins, i_Data, i_we_ien, i_we_edge, i_we_pol, i_we_clr,
        input  o_level, o_status, o_ien, o_edge, o_pol, o_irq
    );

    modport slave (
        input  i_pins, i_Data, i_we_ien, i_we_edge, i_we_pol, i_we_clr,
        output o_level, o_status, o_ien, o_edge, o_pol, o_irq
    );
endinterface

// File: rtl/gpio_irq_in.sv
// GPIO input side: 2-flop synchroniser, optional debounce (GPIO_IN_DEBOUNCE_EN),
// per-bit edge/level event detection, sticky W1C STATUS and a single IRQ line.
module gpio_irq_in #(
    parameter int WIDTH      = 32,
    parameter int DEB_CYCLES = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    gpio_irq_in_if.slave  bus
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr_mask;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int             CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // filt only follows s2 after the mismatch has persisted DEB_CYCLES clocks
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign filt = filt_q;
`else
    logic unused_deb_cfg;
    assign unused_deb_cfg = (DEB_CYCLES > 1);
    assign filt = s2_q;
`endif

    always_comb begin
        s1_d   = bus.i_pins;
        s2_d   = s1_q;
        prev_d = filt;
        ien_d  = bus.i_we_ien  ? bus.i_Data : ien_q;
        edge_d = bus.i_we_edge ? bus.i_Data : edge_q;
        pol_d  = bus.i_we_pol  ? bus.i_Data : pol_q;

        rise = filt & ~prev_q;
        fall = ~filt & prev_q;
        // edge bits pick rise/fall by POL; level bits fire while filt matches POL
        evt  = (edge_q & ((pol_q & rise) | (~pol_q & fall)))
             | (~edge_q & ~(filt ^ pol_q));

        clr_mask = bus.i_we_clr ? bus.i_Data : '0;
        status_d = (status_q & ~clr_mask) | evt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            ien_q    <= '0;
            edge_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            ien_q    <= ien_d;
            edge_q   <= edge_d;
            pol_q    <= pol_d;
            status_q <= status_d;
        end
    end

    assign bus.o_level  = filt;
    assign bus.o_status = status_q;
    assign bus.o_ien    = ien_q;
    assign bus.o_edge   = edge_q;
    assign bus.o_pol    = pol_q;
    assign bus.o_irq    = |(status_q & ien_q);

endmodule

// File: tb/tb_gpio_irq_in.sv
// Directed bench for gpio_irq_in; expected values queued as stimulus is applied.
module tb_gpio_irq_in;
    localparam int W = 32;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif
    localparam logic [3:0] WE_IEN  = 4'b1000;
    localparam logic [3:0] WE_EDGE = 4'b0100;
    localparam logic [3:0] WE_POL  = 4'b0010;
    localparam logic [3:0] WE_CLR  = 4'b0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gpio_irq_in_if #(.WIDTH(W)) bus ();

    gpio_irq_in #(.WIDTH(W), .DEB_CYCLES(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        string          tag;
        logic [W-1:0]   val;
    } exp_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic push(input string tag, input logic [W-1:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [W-1:0] obs);
        exp_t e;
        ntests++;
        if (sb.size() == 0) begin
            nfail++;
            $error("FAIL sb_empty: got %h expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                nfail++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] we, input logic [W-1:0] d);
        bus.i_Data = d;
        {bus.i_we_ien, bus.i_we_edge, bus.i_we_pol, bus.i_we_clr} = we;
        tick(1);
        {bus.i_we_ien, bus.i_we_edge, bus.i_we_pol, bus.i_we_clr} = '0;
    endtask

    task automatic chk_all_zero(input string pfx);
        push({pfx, "_status"}, '0);
        push({pfx, "_level"},  '0);
        push({pfx, "_ien"},    '0);
        push({pfx, "_edge"},   '0);
        push({pfx, "_pol"},    '0);
        push({pfx, "_irq"},    '0);
        chk(bus.o_status);
        chk(bus.o_level);
        chk(bus.o_ien);
        chk(bus.o_edge);
        chk(bus.o_pol);
        chk(W'(bus.o_irq));
    endtask

    initial begin
        bus.i_pins    = '0;
        bus.i_Data    = '0;
        bus.i_we_ien  = 1'b0;
        bus.i_we_edge = 1'b0;
        bus.i_we_pol  = 1'b0;
        bus.i_we_clr  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("rst");
        tick(2);
        rst_n = 1'b1;

        // bits 1 level-high, 0/5/6 rising, rest falling
        push("cfg_edge", ~32'h2);
        push("cfg_pol",  32'h63);
        push("cfg_ien",  32'h3);
        wr(WE_EDGE, ~32'h2);
        wr(WE_POL,  32'h63);
        wr(WE_IEN,  32'h3);
        chk(bus.o_edge);
        chk(bus.o_pol);
        chk(bus.o_ien);
        push("init_clr", '0);
        wr(WE_CLR, '1);
        chk(bus.o_status);

        // rising edge on bit 0
        bus.i_pins[0] = 1'b1;
        push("rise_early", '0);
        push("rise_status", 32'h1);
        push("rise_irq", 32'h1);
        push("rise_level", 32'h1);
        tick(2 + FL);
        chk(bus.o_status);
        tick(1);
        chk(bus.o_status);
        chk(W'(bus.o_irq));
        chk(bus.o_level);
        push("clr_status", '0);
        push("clr_irq", '0);
        wr(WE_CLR, 32'h1);
        chk(bus.o_status);
        chk(W'(bus.o_irq));

        // level-high on bit 1
        bus.i_pins[1] = 1'b1;
        push("lvl_status", 32'h2);
        push("lvl_irq", 32'h1);
        push("lvl_hold", 32'h2);
        tick(3 + FL);
        chk(bus.o_status);
        chk(W'(bus.o_irq));
        wr(WE_CLR, 32'h2);
        chk(bus.o_status);
        bus.i_pins[1] = 1'b0;
        push("lvl_clr", '0);
        push("lvl_clr_irq", '0);
        tick(2 + FL);
        wr(WE_CLR, 32'h2);
        chk(bus.o_status);
        chk(W'(bus.o_irq));

        // rising edge on bit 5 coincides with its clear
        bus.i_pins[5] = 1'b1;
        push("col_early", '0);
        push("col_set_wins", 32'h20);
        push("col_clr", '0);
        tick(2 + FL);
        chk(bus.o_status);
        wr(WE_CLR, 32'h20);
        chk(bus.o_status);
        wr(WE_CLR, 32'h20);
        chk(bus.o_status);

        // falling edge on bit 31 with IEN masked
        bus.i_pins[31] = 1'b1;
        push("b31_rise_ignored", '0);
        tick(4 + FL);
        chk(bus.o_status);
        bus.i_pins[31] = 1'b0;
        push("b31_fall_status", 32'h8000_0000);
        push("b31_masked_irq", '0);
        push("b31_unmask_irq", 32'h1);
        push("b31_ien", 32'h8000_0003);
        push("b31_cfg_keeps_status", 32'h8000_0000);
        tick(3 + FL);
        chk(bus.o_status);
        chk(W'(bus.o_irq));
        wr(WE_IEN, 32'h8000_0003);
        chk(W'(bus.o_irq));
        chk(bus.o_ien);
        chk(bus.o_status);
        push("b31_clr", '0);
        wr(WE_CLR, '1);
        chk(bus.o_status);

`ifdef GPIO_IN_DEBOUNCE_EN
        // 3-cycle glitch on bit 6 rejected, sustained high accepted
        bus.i_pins[6] = 1'b1;
        tick(3);
        bus.i_pins[6] = 1'b0;
        push("deb_glitch_level", 32'h21);
        push("deb_glitch_status", '0);
        tick(6);
        chk(bus.o_level);
        chk(bus.o_status);
        bus.i_pins[6] = 1'b1;
        push("deb_level_e5", 32'h21);
        push("deb_level_e6", 32'h61);
        push("deb_status_e6", '0);
        push("deb_status_e7", 32'h40);
        tick(5);
        chk(bus.o_level);
        tick(1);
        chk(bus.o_level);
        chk(bus.o_status);
        tick(1);
        chk(bus.o_status);
        push("deb_clr", '0);
        wr(WE_CLR, '1);
        chk(bus.o_status);
`endif

        // fill STATUS with level-high events on bits 7:0, then reset mid-run
        bus.i_pins = 32'hFF;
        tick(3 + FL);
        wr(WE_POL, '1);
        wr(WE_EDGE, '0);
        push("pre_rst_status", 32'hFF);
        push("pre_rst_level", 32'hFF);
        tick(1);
        chk(bus.o_status);
        chk(bus.o_level);
        rst_n = 1'b0;
        #2;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr(WE_EDGE | WE_POL, '1);
        wr(WE_CLR, '1);
        push("post_rst_clr", '0);
        push("post_rst_quiet", '0);
        push("post_rst_rise", 32'hFF);
        push("post_rst_irq", '0);
        chk(bus.o_status);
        tick(FL);
        chk(bus.o_status);
        tick(1);
        chk(bus.o_status);
        chk(W'(bus.o_irq));

        if (sb.size() != 0) begin
            ntests++;
            nfail++;
            $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
